sha2_block_sequencer: RTL
=========================

// Module: sha2_block_sequencer
// PURPOSE
//  Sequences sha2_core across a multi-block SHA-2 message: latches the mode, re-initialises the core IV,
//  buffers 16 pre-padded words per block, burst-loads them, and runs the rounds until end_op.
//  It chains the blocks and presents the truncated digest with a valid/ready handshake.
//  Sits between the host/bus word stream and a single sha2_core instance. The next block fills while the core runs.
// PARAMETERS
//  WORDS_PER_BLK  16  words per block; fixed for all modes (SHA-256 words occupy bits [31:0])
//  DW             64  word width of in_data / core_data_in
// PORTS
//  clk           in   1    clock; all logic on posedge
//  rst           in   1    reset, synchronous, active-high
//  mode          in   4    one-hot {512_256,512,384,256}; sampled only on an accepted msg_start
//  msg_start     in   1    pulse: begin a new message; ignored unless busy=0
//  in_valid      in   1    word-stream valid
//  in_data       in   DW   message word, big-endian word order, padding already applied
//  in_last       in   1    marks word 15 of the final block
//  in_ready      out  1    word accepted when in_valid&in_ready
//  digest        out  512  left-aligned digest; unused LSBs zero
//  digest_valid  out  1    digest stable; held until digest_ready
//  digest_ready  in   1    consumer accepts digest
//  busy          out  1    state != IDLE
//  err           out  1    1-cycle pulse on protocol error
//  core_rst_n    out  1    to sha2_core rst (active-low)
//  core_mode     out  4    to sha2_core mode (latched mode)
//  core_load     out  1    to sha2_core load
//  core_start    out  1    to sha2_core start
//  core_data_in  out  DW   to sha2_core data_in
//  core_end_op   in   1    from sha2_core end_op
//  core_H_out    in   512  from sha2_core H_out (chaining value)
// BEHAVIOUR
//  Reset: state=IDLE. Buffer count, word index and last_seen = 0. core_rst_n, in_ready, core_load,
//   core_start, digest_valid, busy, err = 0. digest = 0. core_mode holds the last latched mode (0 after reset).
//  States: IDLE, INIT, WAITBUF, LOAD, RUN, SAVE, DONE.
//  IDLE -> INIT on msg_start with exactly one mode bit set: latch mode, clear last_seen.
//   If msg_start arrives with a mode that is not one-hot: err pulse, stay IDLE.
//  INIT (1 cycle): core_rst_n=0 so the core loads the IV for core_mode -> WAITBUF.
//  WAITBUF: wait for buf_cnt==16 -> LOAD.
//  LOAD (16 cycles): core_load=1, core_data_in=buf[idx], idx 0..15.
//   Buffer count clears on the last LOAD cycle -> RUN.
//  RUN: core_start=1 until core_end_op==1 is sampled -> SAVE, with core_start=0 in SAVE.
//   RUN must complete in <=82 cycles.
//  SAVE (1 cycle): the core adds the chaining value into H_out during this cycle.
//   If the block just run was the last: -> DONE. Otherwise -> LOAD when buf_cnt==16, else WAITBUF.
//  DONE: capture digest from core_H_out on entry; digest_valid=1.
//   On digest_ready -> IDLE, with digest_valid cleared the next cycle.
//  Digest packing, {a..h} = core_H_out 64-bit fields, MSB first:
//   SHA-256: {a[31:0],b[31:0],...,h[31:0],256'b0}.
//   384: {a..f,128'b0}. 512: {a..h}. 512/256: {a..d,256'b0}.
//  Buffer: 16xDW registers, write index = buf_cnt.
//   in_ready = state in {WAITBUF,RUN,SAVE} & buf_cnt<16 & !last_seen. in_ready=0 during LOAD.
//   A block is "last" when in_last was accepted with its word 15.
//  Errors (err pulse, state -> IDLE, core_rst_n=0 for 1 cycle, buffer cleared):
//   in_last accepted on a word other than word 15 of its block.
//  msg_start while busy: ignored, no err. rst mid-operation: immediate return to reset state, digest discarded.
//  Simultaneous events: word accept and LOAD never overlap. digest_ready outside DONE is ignored.
// TESTING
//  SHA-256 "abc": words 0x61626380, 0x0 x14, 0x18 (in_last) ->
//   digest[511:256]=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  SHA-512 "abc": 0x6162638000000000, 0x0 x14, 0x18 -> digest=ddaf35a193617aba...a54ca49f, all 512 bits.
//  Two-block SHA-256 "abcdbcdecdef...nopq" (448-bit) -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//   Check that in_ready rises during the first RUN.
//  in_valid toggling randomly and digest_ready delayed 10 cycles -> same digests; digest_valid held steady.
//  in_last on word 7 -> err 1 cycle, busy=0, core_rst_n pulse. Next msg_start with mode=4'b0011 -> err, stays IDLE.
//  rst asserted in RUN -> next cycle state IDLE, all outputs at reset values. A following "abc" SHA-256 run still gives the correct digest.

Source files
------------

// File: rtl/sha2_block_sequencer.sv
// Block sequencer for a single sha2_core: buffers one 16-word block while the core
// runs the previous one, chains blocks and hands out the truncated digest.
module sha2_block_sequencer #(
    parameter int WORDS_PER_BLK = 16,
    parameter int DW            = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    mode,
    input  logic          msg_start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [511:0]  digest,
    output logic          digest_valid,
    input  logic          digest_ready,
    output logic          busy,
    output logic          err,
    output logic          core_rst_n,
    output logic [3:0]    core_mode,
    output logic          core_load,
    output logic          core_start,
    output logic [DW-1:0] core_data_in,
    input  logic          core_end_op,
    input  logic [511:0]  core_H_out
);
    localparam int CW = $clog2(WORDS_PER_BLK + 1);
    localparam int IW = $clog2(WORDS_PER_BLK);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_WAITBUF = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_SAVE    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state;
    logic [DW-1:0] buf_q [WORDS_PER_BLK];
    logic [CW-1:0] buf_cnt;
    logic [IW-1:0] idx;
    logic [3:0]    mode_q;
    logic          last_seen;
    logic          blk_last;
    logic          buf_full;
    logic          accept;
    logic          last_err;
    logic          mode_ok;

    // Truncate the chaining value to the mode's digest, left-aligned.
    function automatic logic [511:0] pack_digest(input logic [3:0] m, input logic [511:0] h);
        logic [511:0] r;
        r = '0;
        if (m[0]) begin
            for (int i = 0; i < 8; i++)
                r[511-32*i -: 32] = h[479-64*i -: 32];
        end else if (m[1]) begin
            r[511:128] = h[511:128];
        end else if (m[2]) begin
            r = h;
        end else begin
            r[511:256] = h[511:256];
        end
        return r;
    endfunction

    assign buf_full = (buf_cnt == CW'(WORDS_PER_BLK));
    assign in_ready = ((state == S_WAITBUF) || (state == S_RUN) || (state == S_SAVE))
                      && !buf_full && !last_seen;
    assign accept   = in_valid && in_ready;
    assign last_err = accept && in_last && (buf_cnt != CW'(WORDS_PER_BLK - 1));
    assign mode_ok  = (mode != 4'd0) && ((mode & (mode - 4'd1)) == 4'd0);

    assign busy         = (state != S_IDLE);
    // Core is held in reset while idle and pulsed low in INIT to reload its IV.
    assign core_rst_n   = (state != S_IDLE) && (state != S_INIT);
    assign core_mode    = mode_q;
    assign core_load    = (state == S_LOAD);
    assign core_start   = (state == S_RUN);
    assign core_data_in = buf_q[idx];

    always_ff @(posedge clk) begin
        if (accept)
            buf_q[buf_cnt[IW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            buf_cnt      <= '0;
            idx          <= '0;
            last_seen    <= 1'b0;
            blk_last     <= 1'b0;
            mode_q       <= 4'd0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                buf_cnt <= buf_cnt + CW'(1);
                if (in_last)
                    last_seen <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (msg_start) begin
                        if (mode_ok) begin
                            mode_q    <= mode;
                            last_seen <= 1'b0;
                            state     <= S_INIT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_INIT:    state <= S_WAITBUF;
                S_WAITBUF: if (buf_full) state <= S_LOAD;
                S_LOAD: begin
                    idx <= idx + IW'(1);
                    if (idx == IW'(WORDS_PER_BLK - 1)) begin
                        idx      <= '0;
                        buf_cnt  <= '0;
                        blk_last <= last_seen;
                        state    <= S_RUN;
                    end
                end
                S_RUN: if (core_end_op) state <= S_SAVE;
                S_SAVE: begin
                    if (blk_last)      state <= S_DONE;
                    else if (buf_full) state <= S_LOAD;
                    else               state <= S_WAITBUF;
                end
                S_DONE: begin
                    // H_out settles during SAVE, so capture on the first DONE cycle.
                    if (!digest_valid) begin
                        digest       <= pack_digest(mode_q, core_H_out);
                        digest_valid <= 1'b1;
                    end else if (digest_ready) begin
                        digest_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (last_err) begin
                err       <= 1'b1;
                state     <= S_IDLE;
                buf_cnt   <= '0;
                last_seen <= 1'b0;
            end
        end
    end
endmodule
